prog_clk_divider: RTL and testbench

Multi-channel clock divider. Each channel generates a square-wave divided clock and a one-cycle rising-edge tick strobe from the 50 MHz system clock. Each channel has its own enable and a half-period that can be reprogrammed at runtime through a load/ack handshake. New half-periods take effect glitch-free at the channel's next toggle. The block feeds the slow-rate consumers in the design: display scan, debounce sampling, blink timers and the lockout timer.

---
 rtl/prog_clk_divider.sv | 94 +++++++++
 tb/tb_prog_clk_divider.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: per-channel 50% square wave plus rising-edge tick.
// Latency: load response one cycle after ld; new half-period applied at the channel's next toggle.
// Backpressure: none; every ld cycle gets exactly one ld_ack or ld_err pulse.
module prog_clk_divider #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DEF_FREQ = 1,
  parameter int N_CH     = 4,
  parameter int DIV_W    = 32,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             ld,
  input  logic [CH_W-1:0]  ld_ch,
  input  logic [DIV_W-1:0] ld_half,
  output logic             ld_ack,
  output logic             ld_err,
  output logic [N_CH-1:0]  clk_div,
  output logic [N_CH-1:0]  tick
);

  localparam int DEF_HALF_I = CLK_FREQ / (2 * DEF_FREQ);
  localparam logic [DIV_W-1:0] DEF_HALF = (DEF_HALF_I < 1) ? DIV_W'(1) : DIV_W'(DEF_HALF_I);

  typedef struct packed {
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] pend;
    logic             pend_vld;
  } ch_t;

  ch_t             ch_q [N_CH];
  logic            ld_acc;
  logic [N_CH-1:0] ld_hit;
  logic [N_CH-1:0] wrap;

  // A zero half-period would never wrap, so it is rejected along with out-of-range channels.
  always_comb begin
    ld_acc = ld && (ld_half != '0) && (32'(ld_ch) < N_CH);
    ld_hit = '0;
    wrap   = '0;
    for (int i = 0; i < N_CH; i++) begin
      ld_hit[i] = ld_acc && (ld_ch == CH_W'(i));
      wrap[i]   = en[i] && (ch_q[i].count == ch_q[i].half - DIV_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_ack  <= 1'b0;
      ld_err  <= 1'b0;
      clk_div <= '0;
      tick    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        ch_q[i].count    <= '0;
        ch_q[i].half     <= DEF_HALF;
        ch_q[i].pend     <= '0;
        ch_q[i].pend_vld <= 1'b0;
      end
    end else begin
      ld_ack <= ld_acc;
      ld_err <= ld && !ld_acc;
      for (int i = 0; i < N_CH; i++) begin
        if (!en[i]) begin
          ch_q[i].count <= '0;
          clk_div[i]    <= 1'b0;
          tick[i]       <= 1'b0;
          if (ch_q[i].pend_vld) begin
            ch_q[i].half     <= ch_q[i].pend;
            ch_q[i].pend_vld <= 1'b0;
          end
        end else if (wrap[i]) begin
          ch_q[i].count <= '0;
          clk_div[i]    <= ~clk_div[i];
          tick[i]       <= ~clk_div[i];
          if (ch_q[i].pend_vld) begin
            ch_q[i].half     <= ch_q[i].pend;
            ch_q[i].pend_vld <= 1'b0;
          end
        end else begin
          ch_q[i].count <= ch_q[i].count + DIV_W'(1);
          tick[i]       <= 1'b0;
        end
        // A load landing on a wrap cycle stays pending; the wrap above used the old value.
        if (ld_hit[i]) begin
          ch_q[i].pend     <= ld_half;
          ch_q[i].pend_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: per-cycle vector table plus hand-timed corner sequences.
module tb_prog_clk_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        ld;
  logic [1:0]  ld_ch;
  logic [31:0] ld_half;
  logic        ld_ack, ld_err;
  logic [3:0]  clk_div, tick;

  logic [2:0]  en3;
  logic        ld3;
  logic [1:0]  ld_ch3;
  logic [31:0] ld_half3;
  logic        ld_ack3, ld_err3;
  logic [2:0]  clk_div3, tick3;

  int ntest = 0;
  int nfail = 0;
  int ec    = 0;

  always #5 clk = ~clk;

  prog_clk_divider #(.CLK_FREQ(20), .DEF_FREQ(2), .N_CH(4), .DIV_W(32)) u_dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_ch(ld_ch), .ld_half(ld_half),
    .ld_ack(ld_ack), .ld_err(ld_err), .clk_div(clk_div), .tick(tick)
  );

  // Three-channel instance so that an unused channel code exists for range rejection.
  prog_clk_divider #(.CLK_FREQ(20), .DEF_FREQ(2), .N_CH(3), .DIV_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .en(en3), .ld(ld3), .ld_ch(ld_ch3), .ld_half(ld_half3),
    .ld_ack(ld_ack3), .ld_err(ld_err3), .clk_div(clk_div3), .tick(tick3)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic        ld;
    logic [1:0]  ch;
    logic [31:0] half;
    logic [3:0]  cd;
    logic [3:0]  tk;
    logic        ack;
    logic        err;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic r, input logic [3:0] e, input logic l,
                              input logic [1:0] c, input logic [31:0] h,
                              input logic [3:0] cd, input logic [3:0] tk,
                              input logic a, input logic er);
    vec_t v;
    v.rst = r; v.en = e; v.ld = l; v.ch = c; v.half = h;
    v.cd = cd; v.tk = tk; v.ack = a; v.err = er;
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    ec++;
  endtask

  task automatic goto(input int n);
    while (ec < n) step();
  endtask

  task automatic chk_all(input string nm, input logic [3:0] cd, input logic [3:0] tk);
    chk({nm, " clk_div"}, 32'(clk_div), 32'(cd));
    chk({nm, " tick"}, 32'(tick), 32'(tk));
  endtask

  initial begin
    rst = 1'b0; en = 4'b0; ld = 1'b0; ld_ch = 2'd0; ld_half = 32'd0;
    en3 = 3'b0; ld3 = 1'b0; ld_ch3 = 2'd0; ld_half3 = 32'd0;

    // Reset, default divide by 10, two rejections, then runtime reload of channel 1.
    add(0, 4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    add(0, 4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    for (int k = 0; k < 4; k++) add(1, 4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 0); // e1-4
    add(1, 4'hF, 0, 0, 0, 4'hF, 4'hF, 0, 0);                              // e5
    for (int k = 0; k < 4; k++) add(1, 4'hF, 0, 0, 0, 4'hF, 4'h0, 0, 0); // e6-9
    for (int k = 0; k < 5; k++) add(1, 4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 0); // e10-14
    add(1, 4'hF, 0, 0, 0, 4'hF, 4'hF, 0, 0);                              // e15
    add(1, 4'hF, 1, 0, 0, 4'hF, 4'h0, 0, 1);                              // e16 half=0
    add(1, 4'hF, 1, 3, 0, 4'hF, 4'h0, 0, 1);                              // e17 half=0
    add(1, 4'hF, 0, 0, 0, 4'hF, 4'h0, 0, 0);                              // e18
    add(1, 4'hF, 0, 0, 0, 4'hF, 4'h0, 0, 0);                              // e19
    for (int k = 0; k < 5; k++) add(1, 4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 0); // e20-24
    add(1, 4'hF, 0, 0, 0, 4'hF, 4'hF, 0, 0);                              // e25
    add(1, 4'hF, 0, 0, 0, 4'hF, 4'h0, 0, 0);                              // e26
    add(1, 4'hF, 1, 1, 2, 4'hF, 4'h0, 1, 0);                              // e27 load ch1=2
    add(1, 4'hF, 0, 0, 0, 4'hF, 4'h0, 0, 0);                              // e28
    add(1, 4'hF, 0, 0, 0, 4'hF, 4'h0, 0, 0);                              // e29
    add(1, 4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 0);                              // e30
    add(1, 4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 0);                              // e31
    add(1, 4'hF, 0, 0, 0, 4'h2, 4'h2, 0, 0);                              // e32
    add(1, 4'hF, 0, 0, 0, 4'h2, 4'h0, 0, 0);                              // e33
    add(1, 4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 0);                              // e34
    add(1, 4'hF, 0, 0, 0, 4'hD, 4'hD, 0, 0);                              // e35
    add(1, 4'hF, 0, 0, 0, 4'hF, 4'h2, 0, 0);                              // e36
    add(1, 4'hF, 0, 0, 0, 4'hF, 4'h0, 0, 0);                              // e37
    add(1, 4'hF, 0, 0, 0, 4'hD, 4'h0, 0, 0);                              // e38

    @(negedge clk);
    foreach (tv[k]) begin
      rst = tv[k].rst; en = tv[k].en; ld = tv[k].ld; ld_ch = tv[k].ch; ld_half = tv[k].half;
      step();
      chk($sformatf("row%0d clk_div", k), 32'(clk_div), 32'(tv[k].cd));
      chk($sformatf("row%0d tick", k), 32'(tick), 32'(tv[k].tk));
      chk($sformatf("row%0d ld_ack", k), 32'(ld_ack), 32'(tv[k].ack));
      chk($sformatf("row%0d ld_err", k), 32'(ld_err), 32'(tv[k].err));
    end
    ld = 1'b0;

    // Wrap collision and last-wins on channel 0, from a fresh reset.
    rst = 1'b0; en = 4'hF;
    step();
    chk_all("reset", 4'h0, 4'h0);
    chk("reset ld_ack", 32'(ld_ack), 32'd0);
    rst = 1'b1; ec = 0;
    goto(2);
    ld3 = 1'b1; ld_ch3 = 2'd3; ld_half3 = 32'd4;
    step();
    chk("n3 ch3 ld_err", 32'(ld_err3), 32'd1);
    chk("n3 ch3 ld_ack", 32'(ld_ack3), 32'd0);
    ld_ch3 = 2'd2;
    step();
    chk("n3 ch2 ld_ack", 32'(ld_ack3), 32'd1);
    chk("n3 ch2 ld_err", 32'(ld_err3), 32'd0);
    ld3 = 1'b0;
    goto(7);
    ld = 1'b1; ld_ch = 2'd0; ld_half = 32'd3;
    step();
    chk("coll load3 ack", 32'(ld_ack), 32'd1);
    ld = 1'b0;
    step();
    ld = 1'b1; ld_half = 32'd7;
    step();
    chk("coll load7 ack", 32'(ld_ack), 32'd1);
    chk("coll e10 cd0", 32'(clk_div[0]), 32'd0);
    ld = 1'b0;
    goto(12); chk("coll e12 cd0", 32'(clk_div[0]), 32'd0);
    step();   chk("coll e13 cd0", 32'(clk_div[0]), 32'd1);
              chk("coll e13 tk0", 32'(tick[0]), 32'd1);
    goto(15); chk("coll e15 cd1", 32'(clk_div[1]), 32'd1);
              chk("coll e15 tk1", 32'(tick[1]), 32'd1);
    goto(19); chk("coll e19 cd0", 32'(clk_div[0]), 32'd1);
    step();   chk("coll e20 cd0", 32'(clk_div[0]), 32'd0);
    goto(26); chk("coll e26 cd0", 32'(clk_div[0]), 32'd0);
    step();   chk("coll e27 cd0", 32'(clk_div[0]), 32'd1);
              chk("coll e27 tk0", 32'(tick[0]), 32'd1);
    goto(29);
    ld = 1'b1; ld_ch = 2'd0; ld_half = 32'd4;
    step();
    ld_half = 32'd6;
    step();
    ld = 1'b0;
    goto(33); chk("last e33 cd0", 32'(clk_div[0]), 32'd1);
    step();   chk("last e34 cd0", 32'(clk_div[0]), 32'd0);
    goto(39); chk("last e39 cd0", 32'(clk_div[0]), 32'd0);
    step();   chk("last e40 cd0", 32'(clk_div[0]), 32'd1);
              chk("last e40 tk0", 32'(tick[0]), 32'd1);
    goto(45); chk("last e45 cd0", 32'(clk_div[0]), 32'd1);
              chk("en e45 cd2", 32'(clk_div[2]), 32'd1);
    step();   chk("last e46 cd0", 32'(clk_div[0]), 32'd0);

    // Disable channel 2 while high, load half=1, re-enable.
    en = 4'b1011;
    step();   chk("dis e47 cd2", 32'(clk_div[2]), 32'd0);
    ld = 1'b1; ld_ch = 2'd2; ld_half = 32'd1;
    step();   chk("dis load ack", 32'(ld_ack), 32'd1);
    ld = 1'b0;
    step();   chk("dis e49 cd2", 32'(clk_div[2]), 32'd0);
    en = 4'hF;
    step();   chk("ren e50 cd2", 32'(clk_div[2]), 32'd1);
              chk("ren e50 tk2", 32'(tick[2]), 32'd1);
    step();   chk("ren e51 cd2", 32'(clk_div[2]), 32'd0);
              chk("ren e51 tk2", 32'(tick[2]), 32'd0);
    step();   chk("ren e52 cd2", 32'(clk_div[2]), 32'd1);
              chk("ren e52 tk2", 32'(tick[2]), 32'd1);
    step();   chk("ren e53 cd2", 32'(clk_div[2]), 32'd0);

    // Pending loads everywhere, then a one-cycle reset restores the default timing.
    for (int c = 0; c < 4; c++) begin
      ld = 1'b1; ld_ch = 2'(c); ld_half = (c == 3) ? 32'hFFFF_FFFF : 32'd9;
      step();
      chk($sformatf("pend ch%0d ack", c), 32'(ld_ack), 32'd1);
    end
    ld = 1'b0; rst = 1'b0;
    step();
    chk_all("mid reset", 4'h0, 4'h0);
    chk("mid reset ld_ack", 32'(ld_ack), 32'd0);
    rst = 1'b1; ec = 0;
    goto(4);  chk_all("post e4", 4'h0, 4'h0);
    step();   chk_all("post e5", 4'hF, 4'hF);
    goto(9);  chk_all("post e9", 4'hF, 4'h0);
    step();   chk_all("post e10", 4'h0, 4'h0);
    goto(15); chk_all("post e15", 4'hF, 4'hF);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
